// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the 4x4 matrix keypad scanner.
//   - state_t      : scanner FSM states
//   - scan_ctx_t   : FSM context register (state, row index, latched column).
//                    Lets a checker bind to one named signal.
//   - KEY_MAP      : 16 x 4-bit hex codes, indexed by {row, col}
//   - key_lookup   : map (row, col) to its hex code
//   - lowest_zero  : index of the lowest low column line
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Encodings are fixed so that legacy logic comparing raw 2-bit codes
  // keeps working.
  localparam logic [1:0] S_SCAN       = 2'd0;
  localparam logic [1:0] S_DB_PRESS   = 2'd1;
  localparam logic [1:0] S_HELD       = 2'd2;
  localparam logic [1:0] S_DB_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    SCAN       = S_SCAN,
    DB_PRESS   = S_DB_PRESS,
    HELD       = S_HELD,
    DB_RELEASE = S_DB_RELEASE
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] row;
    logic [1:0] col;
  } scan_ctx_t;

  // Element index is {row, col}. The leftmost entry is index 15 (r3,c3).
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row,
                                            input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

  // Several keys on one row: the lowest column wins. Only called with at
  // least one zero bit present; all-ones falls through to column 3.
  function automatic logic [1:0] lowest_zero(input logic [NUM_COLS-1:0] v);
    logic [1:0] idx;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// col_sync
//   Two-flop synchronizer for asynchronous, active-low column lines.
//   Reset value is all-ones, i.e. "no key pressed".
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-low
//   d      : raw asynchronous inputs
//   q      : synchronized outputs (two clk edges of latency)
module col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time, debounces the
//   selected column and reports a single key as a press level plus a hex
//   code. While a key is held every other key is ignored.
// Parameters:
//   SCAN_CYCLES     : cycles each row is driven before sampling (>= 3)
//   DEBOUNCE_CYCLES : stable samples needed to accept press/release (>= 1)
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-low
//   cols   : raw column lines, active-low, asynchronous
//   rows   : row drive, active-low, exactly one bit low
//   press  : high while a debounced key is held
//   key    : hex code of the accepted key, stable while press=1
//
// Handshake: none. press is a level; key is valid whenever press=1 and
// only changes on the same edge that press rises.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4800,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  output logic                press,
  output logic [3:0]          key
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                            : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DB_DONE   = CW'(DEBOUNCE_CYCLES);

  logic [NUM_COLS-1:0] cs;        // synchronized columns
  scan_ctx_t           ctx_q;     // FSM state, row index, latched column
  logic [CW-1:0]       cnt_q;     // shared dwell / debounce counter
  logic                press_q;
  logic [3:0]          key_q;

  logic                col_high;  // latched column currently released
  logic [CW-1:0]       cnt_inc;   // saturating increment

  col_sync #(
    .WIDTH (NUM_COLS)
  ) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (cs)
  );

  assign col_high = cs[ctx_q.col];
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  // Debounce counters accept on the cycle after the count reaches
  // DEBOUNCE_CYCLES, so press rises DEBOUNCE_CYCLES+1 edges after the
  // detecting edge and release behaves symmetrically.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctx_q.state <= SCAN;
      ctx_q.row   <= 2'd0;
      ctx_q.col   <= 2'd0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      key_q       <= 4'h0;
    end else begin
      case (ctx_q.state)
        SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_q <= '0;
            if (cs != '1) begin
              ctx_q.col   <= lowest_zero(cs);
              ctx_q.state <= DB_PRESS;
            end else begin
              ctx_q.row <= ctx_q.row + 2'd1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        DB_PRESS: begin
          if (col_high) begin
            // Bounce: resume scanning on the same row.
            cnt_q       <= '0;
            ctx_q.state <= SCAN;
          end else if (cnt_q == DB_DONE) begin
            key_q       <= key_lookup(ctx_q.row, ctx_q.col);
            press_q     <= 1'b1;
            cnt_q       <= '0;
            ctx_q.state <= HELD;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        HELD: begin
          // Rows and other columns are frozen out until this key releases.
          if (col_high) begin
            cnt_q       <= '0;
            ctx_q.state <= DB_RELEASE;
          end
        end

        DB_RELEASE: begin
          if (!col_high) begin
            cnt_q       <= '0;
            ctx_q.state <= HELD;
          end else if (cnt_q == DB_DONE) begin
            // Moving to the next row lets a second held key be found on a
            // later pass instead of re-detecting this row first.
            press_q     <= 1'b0;
            ctx_q.row   <= ctx_q.row + 2'd1;
            cnt_q       <= '0;
            ctx_q.state <= SCAN;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        default: begin
          ctx_q.state <= SCAN;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign rows  = ~(4'b0001 << ctx_q.row);
  assign press = press_q;
  assign key   = key_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 matrix keypad, synchronizes and debounces the column inputs, and reports one key at a time.
- Produces the press/key pair consumed by the two-digit display shift register: `press` is a debounced level, and `key` is a 4-bit hex code that is stable whenever `press` is high.
- Sits between the keypad pins and the display logic.

## Interface
Parameters:
- SCAN_CYCLES, default 4800: cycles each row is driven before its columns are sampled; minimum 3.
- DEBOUNCE_CYCLES, default 240000: consecutive stable samples required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low
- cols  input  4  raw column lines, active-low, externally pulled up, asynchronous
- rows  output  4  row drive, active-low, exactly one bit low at all times
- press  output  1  high while a debounced key is held
- key  output  4  hex code of the accepted key, valid and stable while press=1

## Operation
- Columns pass through a 2-flop synchronizer; reset value is 4'b1111. All decisions use the synchronized value `cs`.
- Reset state: SCAN, row index 0, rows=4'b1110, press=0, key=0, all counters 0.
- The row index r is 2 bits. In every state, rows = ~(4'b0001 << r).
- Key map (r,c → key):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- States:
  - SCAN: the dwell counter counts 0..SCAN_CYCLES-1 on row r.
    - At the terminal count, if cs != 4'b1111: latch c = index of the lowest zero bit, clear the counter, go to DB_PRESS.
    - Otherwise r wraps to r+1 (3→0) and the counter clears.
  - DB_PRESS: r is held.
    - Each cycle cs[c]=0 increments the counter.
    - If cs[c]=1, return to SCAN on the same r with the counter cleared.
    - When the count reaches DEBOUNCE_CYCLES: key ← map(r,c), press ← 1, go to HELD.
  - HELD: r and c are held; press=1.
    - Other columns and other rows are ignored, so no second key is reported while one is held.
    - If cs[c]=1, clear the counter and go to DB_RELEASE.
  - DB_RELEASE: press stays 1.
    - Each cycle cs[c]=1 increments the counter.
    - If cs[c]=0, return to HELD.
    - When the count reaches DEBOUNCE_CYCLES: press ← 0, r ← r+1, go to SCAN with the counter cleared.
- `key` is not cleared when press falls; it holds the last accepted value until the next accept.
- Simultaneous keys:
  - Several low columns on one row: the lowest column wins.
  - Keys on different rows: the first row scanned wins.
  - A key still held when the first key is released is detected on a later scan pass.
- Counter widths are $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)+1); counters saturate, never wrap.
- Reset asserted in any state returns to the reset state on the next clk edge, with press=0 immediately after that edge.

## Timing
- rows changes on the clk edge that advances r; columns are sampled SCAN_CYCLES cycles later, which covers the 2-cycle synchronizer plus settling.
- Press latency: press rises on the edge DEBOUNCE_CYCLES+1 cycles after the SCAN terminal-count edge that detected the key, provided cs[c] stays low throughout.
- key and press update on the same edge; key is never seen changing while press=1.
- Release latency: press falls DEBOUNCE_CYCLES+1 cycles after the first synchronized high of cs[c].
- Minimum press pulse width: DEBOUNCE_CYCLES+2 cycles.
- Glitch rejection: any bounce shorter than DEBOUNCE_CYCLES cycles produces no press edge.
- Worst-case time to detect a key: 4·SCAN_CYCLES + DEBOUNCE_CYCLES + 3 cycles.

## Structure
- Package keypad_pkg:
  - state enum {SCAN, DB_PRESS, HELD, DB_RELEASE}
  - key-map constant (16×4-bit, indexed {r,c})
  - NUM_ROWS=4 and NUM_COLS=4 localparams
- Sub-module `col_sync`: parameterized-width 2-flop synchronizer with synchronous active-low reset to all-ones.
- Everything else lives in one FSM and datapath inside keypad_scanner.

## Test plan
All scenarios use SCAN_CYCLES=4 and DEBOUNCE_CYCLES=8. A bench keypad model drives cols[c]=0 iff the pressed key's row is low in rows.
- Clean press of '5' (r1,c1) held 100 cycles: press rises once, key=4'h5 at the rise, rows frozen at 4'b1101; release gives press low 9 cycles after cs[1] goes high; rows resume scanning at 4'b1011.
- Bounce on 'A' (r0,c3), toggling every 3 cycles for 30 cycles then steady low: no press during bouncing; press=1, key=4'hA only after 8 stable samples.
- 'E' (r3,c0) and 'F' (r3,c2) pressed together: key=4'hE. Then 'E' is released while 'F' is still held: press falls, then rises again with key=4'hF.
- '0' held, then '7' pressed while press=1: key stays 4'h0, no extra edge. After '0' is released and '7' is still held: a new press with key=4'h7.
- Reset pulled low during DB_RELEASE of '9': next cycle press=0, key=0, rows=4'b1110. With the key still held after reset deasserts, '9' is re-detected.
- Idle for 64 cycles: rows cycles 1110 → 1101 → 1011 → 0111 → 1110, each held for 4 cycles; press stays 0.
